// File: rtl/datapath_pkg.sv
// Shared FU ids, result-status entry, dispatch FSM states and opcode classification.
package datapath_pkg;
  import isa_pkg::*;

  localparam int NSREGS = 32;
  localparam int NMREGS = 16;
  localparam int NFU    = 5;

  typedef logic [2:0] fu_id_t;
  localparam fu_id_t FU_ALU    = 3'd0;
  localparam fu_id_t FU_LDST   = 3'd1;
  localparam fu_id_t FU_BRANCH = 3'd2;
  localparam fu_id_t FU_MLDST  = 3'd3;
  localparam fu_id_t FU_GEMM   = 3'd4;

  typedef struct packed {
    logic   pending;
    fu_id_t fu;
  } rst_entry_t;

  typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, HALTED = 2'd2} dispatch_state_e;

  typedef struct packed {
    fu_id_t      fu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    rst_entry_t  t1;
    rst_entry_t  t2;
    logic [31:0] instr;
    logic [31:0] pc;
  } disp_pkt_t;

  function automatic fu_id_t fu_of(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE:           fu_of = FU_LDST;
      OP_BRANCH, OP_JAL, OP_JALR:  fu_of = FU_BRANCH;
      OP_MLOAD, OP_MSTORE:         fu_of = FU_MLDST;
      OP_GEMM:                     fu_of = FU_GEMM;
      default:                     fu_of = FU_ALU;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OP_ALU, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_MLOAD, OP_GEMM: writes_rd = 1'b1;
      default:                                                   writes_rd = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/isa_pkg.sv
// Opcode map for the dispatch front end. Matrix classes sit in the custom/low slots.
package isa_pkg;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_MLOAD   = 7'h07;
  localparam logic [6:0] OP_GEMM    = 7'h0B;
  localparam logic [6:0] OP_IMM     = 7'h13;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_MSTORE  = 7'h27;
  localparam logic [6:0] OP_ALU     = 7'h33;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_HALT    = 7'h7F;
endpackage

// File: rtl/reg_status_table.sv
// Register result status table: producer tag per register, tag-qualified clear.
// DISPATCH_WB_BYPASS_EN: same-cycle matching clear shows up as ready on the read ports.
module reg_status_table
  import datapath_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 set_en,
  input  logic [IW-1:0]        set_idx,
  input  fu_id_t               set_fu,
  input  logic                 clr_en,
  input  logic [IW-1:0]        clr_idx,
  input  fu_id_t               clr_fu,
  input  logic [1:0][IW-1:0]   rd_idx,
  output rst_entry_t [1:0]     rd_tag,
  input  logic [IW-1:0]        dst_idx,
  output logic                 dst_pend
);
  rst_entry_t tbl [DEPTH];
  logic       clr_hit;

  // A writeback from a stale producer must not free an entry a newer producer owns.
  assign clr_hit  = clr_en & tbl[clr_idx].pending & (tbl[clr_idx].fu == clr_fu);
  assign dst_pend = tbl[dst_idx].pending;

  for (genvar i = 0; i < 2; i++) begin : g_rd
`ifdef DISPATCH_WB_BYPASS_EN
    logic byp;
    assign byp       = clr_hit & (clr_idx == rd_idx[i]);
    assign rd_tag[i] = {tbl[rd_idx[i]].pending & ~byp, tbl[rd_idx[i]].fu};
`else
    assign rd_tag[i] = tbl[rd_idx[i]];
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      if (clr_hit) tbl[clr_idx].pending <= 1'b0;
      // Issued after the clear so a same-register accept takes ownership.
      if (set_en)  tbl[set_idx] <= {1'b1, set_fu};
    end
  end
endmodule

// File: rtl/dispatch_stage.sv
// Dispatch: decode, structural/WAW hazard check, RST update, registered packet, branch/halt FSM.
// DISPATCH_WB_BYPASS_EN selects writeback bypass on source tags (see reg_status_table).
module dispatch_stage
  import datapath_pkg::*;
  import isa_pkg::*;
#(
  parameter int NSREGS = datapath_pkg::NSREGS,
  parameter int NMREGS = datapath_pkg::NMREGS,
  parameter int NFU    = datapath_pkg::NFU
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           fetch_valid,
  output logic           fetch_ready,
  input  logic [31:0]    fetch_instr,
  input  logic [31:0]    fetch_pc,
  input  logic [NFU-1:0] fust_busy,
  input  logic           freeze,
  input  logic           branch_resolved,
  input  logic           branch_miss,
  input  logic           wb_valid,
  input  logic [4:0]     wb_rd,
  input  logic [2:0]     wb_fu,
  input  logic           wbm_valid,
  input  logic [3:0]     wbm_rd,
  input  logic [2:0]     wbm_fu,
  output logic           disp_valid,
  output logic [2:0]     disp_fu,
  output logic [4:0]     disp_rd,
  output logic [4:0]     disp_rs1,
  output logic [4:0]     disp_rs2,
  output logic [3:0]     disp_t1,
  output logic [3:0]     disp_t2,
  output logic [31:0]    disp_instr,
  output logic [31:0]    disp_pc,
  output logic           halt
);
  localparam int SIW = $clog2(NSREGS);
  localparam int MIW = $clog2(NMREGS);

  dispatch_state_e  state;
  disp_pkt_t        pkt;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  fu_id_t           fu;
  logic             writes, is_mat, waw, accept, miss_flush;
  rst_entry_t [1:0] s_tag, m_tag;
  logic             s_dpend, m_dpend;
  rst_entry_t       t1, t2;

  assign opcode = fetch_instr[6:0];
  assign rd     = fetch_instr[11:7];
  assign rs1    = fetch_instr[19:15];
  assign rs2    = fetch_instr[24:20];
  assign fu     = fu_of(opcode);
  assign writes = writes_rd(opcode);
  assign is_mat = (fu == FU_MLDST) | (fu == FU_GEMM);

  reg_status_table #(.DEPTH(NSREGS)) u_srst (
    .CLK(CLK), .nRST(nRST),
    .set_en(accept & writes & ~is_mat & (rd != '0)),
    .set_idx(rd[SIW-1:0]), .set_fu(fu),
    .clr_en(wb_valid), .clr_idx(wb_rd[SIW-1:0]), .clr_fu(wb_fu),
    .rd_idx({rs2[SIW-1:0], rs1[SIW-1:0]}), .rd_tag(s_tag),
    .dst_idx(rd[SIW-1:0]), .dst_pend(s_dpend)
  );

  reg_status_table #(.DEPTH(NMREGS)) u_mrst (
    .CLK(CLK), .nRST(nRST),
    .set_en(accept & writes & is_mat),
    .set_idx(rd[MIW-1:0]), .set_fu(fu),
    .clr_en(wbm_valid), .clr_idx(wbm_rd[MIW-1:0]), .clr_fu(wbm_fu),
    .rd_idx({rs2[MIW-1:0], rs1[MIW-1:0]}), .rd_tag(m_tag),
    .dst_idx(rd[MIW-1:0]), .dst_pend(m_dpend)
  );

  // x0 is hardwired: never a producer, never a dependency.
  always_comb begin
    t1 = is_mat ? m_tag[0] : s_tag[0];
    t2 = is_mat ? m_tag[1] : s_tag[1];
    if (!is_mat && rs1 == '0) t1 = '0;
    if (!is_mat && rs2 == '0) t2 = '0;
  end

  assign waw        = writes & (is_mat ? m_dpend : (s_dpend & (rd != '0)));
  // Mispredict redirect cycle: fetch is re-steering, never take a word here.
  assign miss_flush = (state == BR_WAIT) & branch_resolved & branch_miss;
  assign fetch_ready = nRST & (state == RUN) & ~miss_flush & ~freeze & ~fust_busy[fu] & ~waw;
  assign accept      = fetch_valid & fetch_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pkt        <= '0;
      disp_valid <= 1'b0;
    end else if (!freeze) begin
      disp_valid <= accept;
      if (accept) pkt <= {fu, rd, rs1, rs2, t1, t2, fetch_instr, fetch_pc};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: if (accept) begin
          if (opcode == OP_HALT)     state <= HALTED;
          else if (fu == FU_BRANCH)  state <= BR_WAIT;
        end
        BR_WAIT: if (branch_resolved) state <= RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign halt       = (state == HALTED);
  assign disp_fu    = pkt.fu;
  assign disp_rd    = pkt.rd;
  assign disp_rs1   = pkt.rs1;
  assign disp_rs2   = pkt.rs2;
  assign disp_t1    = pkt.t1;
  assign disp_t2    = pkt.t2;
  assign disp_instr = pkt.instr;
  assign disp_pc    = pkt.pc;
endmodule
